// File: rtl/ula_seq.sv
// ula_seq: command sequencer and result collector for the 6-bit ULA.
// Accepts load/ULA commands, keeps a 4-entry register file, drives the
// ULA operands with registered signals, captures its result into the
// destination register and returns the result on a valid/ready channel.
module ula_seq #(
  parameter int WIDTH = 6,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic             cmd_mode,
  input  logic [2:0]       cmd_oper,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_ra,
  input  logic [1:0]       cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] ula_A,
  output logic [WIDTH-1:0] ula_B,
  output logic             ula_reset,
  output logic             ula_mode,
  output logic [2:0]       ula_oper,
  input  logic [WIDTH-1:0] ula_O,
  input  logic             ula_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_overflow,
  output logic             res_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [1:0]       r_rd;
  logic [WIDTH-1:0] r_ula_a;
  logic [WIDTH-1:0] r_ula_b;
  logic             r_ula_reset;
  logic             r_ula_mode;
  logic [2:0]       r_ula_oper;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_overflow;
  logic             r_res_zero;
  logic             w_accept;

  // Ready depends only on state (and reset), never on cmd_valid.
  assign cmd_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = cmd_valid && cmd_ready;
  assign busy      = (r_state != S_IDLE);

  assign ula_A        = r_ula_a;
  assign ula_B        = r_ula_b;
  assign ula_reset    = r_ula_reset;
  assign ula_mode     = r_ula_mode;
  assign ula_oper     = r_ula_oper;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_overflow = r_res_overflow;
  assign res_zero     = r_res_zero;

  // Next-state decode: loads go straight to RESP, ULA commands take ISSUE then CAPTURE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_load) begin
            w_next = S_RESP;
          end else begin
            w_next = S_ISSUE;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      S_RESP: begin
        if (res_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath: register file, registered ULA drive and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_rd           <= 2'd0;
      r_ula_a        <= '0;
      r_ula_b        <= '0;
      r_ula_reset    <= 1'b1;
      r_ula_mode     <= 1'b0;
      r_ula_oper     <= 3'd0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_res_overflow <= 1'b0;
      r_res_zero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (cmd_load) begin
              r_regs[cmd_rd] <= cmd_imm;
              r_res_data     <= cmd_imm;
              r_res_overflow <= 1'b0;
              r_res_zero     <= (cmd_imm == {WIDTH{1'b0}});
              r_res_valid    <= 1'b1;
            end else begin
              // Sources are sampled here, so rd == ra/rb sees the old value.
              r_ula_a     <= r_regs[cmd_ra];
              r_ula_b     <= r_regs[cmd_rb];
              r_ula_mode  <= cmd_mode;
              r_ula_oper  <= cmd_oper;
              r_rd        <= cmd_rd;
              r_ula_reset <= 1'b0;
            end
          end
        end
        S_CAPTURE: begin
          r_regs[r_rd]   <= ula_O;
          r_res_data     <= ula_O;
          // Carry/borrow is only meaningful for arithmetic (mode 0).
          r_res_overflow <= ula_overflow & ~r_ula_mode;
          r_res_zero     <= (ula_O == {WIDTH{1'b0}});
          r_ula_reset    <= 1'b1;
          r_res_valid    <= 1'b1;
        end
        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
